// File: rtl/rst_seq_debounce.sv
// rst_seq_debounce: per-channel synchroniser and debouncer with one-cycle edge
// flags, feeding an ordered release sequencer for a chain of active-low resets.
//
// Sequencer states
//   state | meaning
//   HOLD  | channel idx still in reset, waiting for its request
//   GAP   | request for channel idx seen, counting the release gap
//   RUN   | every channel released, seq_done_o asserted
module rst_seq_debounce #(
    parameter int N_CH       = 3,
    parameter int DEB_CYCLES = 1000000,
    parameter int DEB_W      = 20,
    parameter int GAP_CYCLES = 1024,
    parameter int GAP_W      = 16,
    parameter bit STICKY     = 1'b1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            arm_i,
    input  logic [N_CH-1:0] btn_i,
    output logic [N_CH-1:0] deb_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic [N_CH-1:0] rst_n_o,
    output logic            seq_done_o
);

    localparam int               IDX_W    = $clog2(N_CH + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CH - 1);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        GAP  = 2'd1,
        RUN  = 2'd2
    } state_t;

    logic [N_CH-1:0]  sync1_q, sync2_q;
    logic [N_CH-1:0]  deb_q, deb_d;
    logic [N_CH-1:0]  rise_q, rise_d;
    logic [N_CH-1:0]  fall_q, fall_d;
    logic [DEB_W-1:0] deb_cnt_q [N_CH];
    logic [DEB_W-1:0] deb_cnt_d [N_CH];
    logic [N_CH-1:0]  req;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [GAP_W-1:0] gap_q;
    logic [N_CH-1:0]  rst_n_q;
    logic             done_q;

    logic             req_cur;
    logic [N_CH-1:0]  rel_mask;
    logic [N_CH-1:0]  drop_mask;
    logic             drop_hit;
    logic [IDX_W-1:0] drop_idx;

    // Two-flop synchroniser; deliberately untouched by arm_i so it keeps tracking the pins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next state: count consecutive mismatch cycles, flip and flag on terminal count.
    always_comb begin
        deb_d  = deb_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            deb_cnt_d[i] = '0;
            if (!arm_i) begin
                deb_d[i] = 1'b0;
            end else if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i]  = sync2_q[i];
                    rise_d[i] = sync2_q[i];
                    fall_d[i] = ~sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounce registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            deb_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < N_CH; i++) deb_cnt_q[i] <= '0;
        end else begin
            deb_q  <= deb_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < N_CH; i++) deb_cnt_q[i] <= deb_cnt_d[i];
        end
    end

    generate
        if (STICKY) begin : g_sticky
            logic [N_CH-1:0] req_q;

            // Latch a request the cycle after its rise flag; only reset or disarm clears it.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    req_q <= '0;
                end else if (!arm_i) begin
                    req_q <= '0;
                end else begin
                    req_q <= req_q | rise_q;
                end
            end

            assign req = req_q;
        end else begin : g_level
            assign req = deb_q;
        end
    endgenerate

    // Decode the current channel and find the lowest released channel whose request dropped.
    always_comb begin
        req_cur   = 1'b0;
        rel_mask  = '0;
        drop_mask = '0;
        drop_hit  = 1'b0;
        drop_idx  = '0;
        for (int j = 0; j < N_CH; j++) begin
            if (IDX_W'(j) == idx_q) begin
                req_cur     = req[j];
                rel_mask[j] = 1'b1;
            end
        end
        for (int j = N_CH - 1; j >= 0; j--) begin
            if ((IDX_W'(j) < idx_q) && !req[j]) begin
                drop_hit = 1'b1;
                drop_idx = IDX_W'(j);
            end
        end
        for (int j = 0; j < N_CH; j++) begin
            drop_mask[j] = (IDX_W'(j) >= drop_idx);
        end
    end

    // Release sequencer; a drop pulls the chain back before any release due on the same edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= HOLD;
            idx_q   <= '0;
            gap_q   <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
        end else if (!arm_i) begin
            state_q <= HOLD;
            idx_q   <= '0;
            gap_q   <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
        end else if (drop_hit) begin
            state_q <= HOLD;
            idx_q   <= drop_idx;
            gap_q   <= '0;
            rst_n_q <= rst_n_q & ~drop_mask;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (req_cur) begin
                        state_q <= GAP;
                        gap_q   <= '0;
                    end
                end
                GAP: begin
                    if (!req_cur) begin
                        state_q <= HOLD;
                        gap_q   <= '0;
                    end else if (gap_q == GAP_LAST) begin
                        rst_n_q <= rst_n_q | rel_mask;
                        idx_q   <= idx_q + 1'b1;
                        gap_q   <= '0;
                        if (idx_q == IDX_LAST) begin
                            state_q <= RUN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= HOLD;
                        end
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                RUN: begin
                end
                default: begin
                    state_q <= HOLD;
                end
            endcase
        end
    end

    assign deb_o      = deb_q;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;
    assign rst_n_o    = rst_n_q;
    assign seq_done_o = done_q;

endmodule
